collision_sched: RTL

- Time-multiplexed collision scheduler for the plane game.
- On each frame tick, snapshots the plane position and up to NUM_OBJ obstacle (rock) positions.
- Sweeps one shared box-overlap comparator across the obstacles, one per cycle, and reports a per-object hit mask and a qualified plane_hit pulse.
- Adds a post-hit invulnerability window of GRACE_FRAMES frames. Sits between the object-motion logic and the game/lives FSM.

---
 rtl/game_pkg.sv | 15 +
 rtl/box_overlap.sv | 37 +++
 rtl/collision_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the plane game collision logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  localparam int COORD_W = 11;  // screen coordinate width
  localparam int CALC_W  = 12;  // one extra bit so coord + offset never wraps

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/box_overlap.sv
// Strict box-overlap test between the plane nose point and one obstacle box.
// Latency: purely combinational.
// Backpressure: none.
module box_overlap
  import game_pkg::*;
#(
  parameter int OBJ_SIZE = 32,
  parameter int PL_XOFF  = 16
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic               active,
  output logic               hit
);

  logic [CALC_W-1:0] nose_x;
  logic [CALC_W-1:0] plane_y;
  logic [CALC_W-1:0] box_x0;
  logic [CALC_W-1:0] box_y0;
  logic [CALC_W-1:0] box_x1;
  logic [CALC_W-1:0] box_y1;

  assign nose_x  = {1'b0, px} + CALC_W'(PL_XOFF);
  assign plane_y = {1'b0, py};
  assign box_x0  = {1'b0, ox};
  assign box_y0  = {1'b0, oy};
  assign box_x1  = {1'b0, ox} + CALC_W'(OBJ_SIZE);
  assign box_y1  = {1'b0, oy} + CALC_W'(OBJ_SIZE);

  // Edges are exclusive: touching a box edge is not a collision.
  assign hit = active
             && (nose_x  > box_x0) && (nose_x  < box_x1)
             && (plane_y > box_y0) && (plane_y < box_y1);

endmodule

// File: rtl/collision_sched.sv
// Per-frame collision scan: one shared comparator swept over NUM_OBJ snapshotted obstacles, plus hit grace window.
// Latency: frame_tick to done is NUM_OBJ+1 cycles; busy for NUM_OBJ+1 cycles.
// Backpressure: none; frame_tick while busy is dropped and flagged on missed_tick.
module collision_sched
  import game_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int OBJ_SIZE     = 32,
  parameter int PL_XOFF      = 16,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [COORD_W-1:0]         px,
  input  logic [COORD_W-1:0]         py,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ-1:0]         obj_active,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_OBJ-1:0]         hit_mask,
  output logic                       plane_hit,
  output logic                       invuln,
  output logic                       missed_tick
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int GR_W  = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [COORD_W-1:0]         px_s_q, px_s_d;
  logic [COORD_W-1:0]         py_s_q, py_s_d;
  logic [NUM_OBJ*COORD_W-1:0] ox_s_q, ox_s_d;
  logic [NUM_OBJ*COORD_W-1:0] oy_s_q, oy_s_d;
  logic [NUM_OBJ-1:0]         act_s_q, act_s_d;
  logic [NUM_OBJ-1:0]         work_q, work_d;
  logic [NUM_OBJ-1:0]         mask_q, mask_d;
  logic [GR_W-1:0]            grace_q, grace_d;
  logic                       invuln_q, invuln_d;

  logic [COORD_W-1:0] cur_ox;
  logic [COORD_W-1:0] cur_oy;
  logic               cur_act;
  logic               cur_hit;

  // Operand mux: select the snapshotted obstacle addressed by the scan index.
  assign cur_ox  = ox_s_q[idx_q*COORD_W +: COORD_W];
  assign cur_oy  = oy_s_q[idx_q*COORD_W +: COORD_W];
  assign cur_act = act_s_q[idx_q];

  box_overlap #(
    .OBJ_SIZE (OBJ_SIZE),
    .PL_XOFF  (PL_XOFF)
  ) u_cmp (
    .px     (px_s_q),
    .py     (py_s_q),
    .ox     (cur_ox),
    .oy     (cur_oy),
    .active (cur_act),
    .hit    (cur_hit)
  );

  // Next-state, datapath updates and done/plane_hit decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    px_s_d    = px_s_q;
    py_s_d    = py_s_q;
    ox_s_d    = ox_s_q;
    oy_s_d    = oy_s_q;
    act_s_d   = act_s_q;
    work_d    = work_q;
    mask_d    = mask_q;
    grace_d   = grace_q;
    done      = 1'b0;
    plane_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          px_s_d  = px;
          py_s_d  = py;
          ox_s_d  = obj_x;
          oy_s_d  = obj_y;
          act_s_d = obj_active;
          work_d  = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
          // The grace window counts accepted frames only.
          if (grace_q != '0) begin
            grace_d = grace_q - GR_W'(1);
          end
        end
      end
      ST_SCAN: begin
        work_d[idx_q] = cur_hit;
        if (idx_q == LAST_IDX) begin
          // Publish the completed mask so it is visible during DONE.
          mask_d  = work_d;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        plane_hit = (mask_q != '0) && (grace_q == '0);
        if (plane_hit) begin
          grace_d = GR_W'(GRACE_FRAMES);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    invuln_d = (grace_d != '0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      px_s_q   <= '0;
      py_s_q   <= '0;
      ox_s_q   <= '0;
      oy_s_q   <= '0;
      act_s_q  <= '0;
      work_q   <= '0;
      mask_q   <= '0;
      grace_q  <= '0;
      invuln_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      px_s_q   <= px_s_d;
      py_s_q   <= py_s_d;
      ox_s_q   <= ox_s_d;
      oy_s_q   <= oy_s_d;
      act_s_q  <= act_s_d;
      work_q   <= work_d;
      mask_q   <= mask_d;
      grace_q  <= grace_d;
      invuln_q <= invuln_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign missed_tick = frame_tick && busy;
  assign hit_mask    = mask_q;
  assign invuln      = invuln_q;

endmodule
